// File: rtl/i2c_fifo.sv
// i2c_fifo: single-clock synchronous FIFO with registered read data,
// occupancy level, almost-full threshold and sticky overflow/underflow flags.
//
// Request semantics: a write is taken on a PCLK edge when WR_ENA=1 and FULL=0;
// a read is taken when RD_ENA=1 and EMPTY=0. Both decisions use the flags as
// they stand before the edge. A taken read presents its word on RDATA with
// RVALID=1 for exactly the following cycle. A refused request changes no
// state except the matching sticky error flag.
module i2c_fifo #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 4,
    parameter int AF_LEVEL = 14
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              WR_ENA,
    input  logic [DWIDTH-1:0] WDATA,
    input  logic              RD_ENA,
    input  logic              ERR_CLR,
    output logic [DWIDTH-1:0] RDATA,
    output logic              RVALID,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL,
    output logic [AWIDTH:0]   LEVEL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic              ERROR
);

    localparam int              DEPTH   = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_L    = (AWIDTH + 1)'(AF_LEVEL);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   level_q,  level_d;
    logic [DWIDTH-1:0] rdata_q,  rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;

    logic full;
    logic empty;
    logic wr_accept;
    logic rd_accept;

    // Status flags are pure decodes of the registered level.
    always_comb begin
        full  = (level_q == DEPTH_L);
        empty = (level_q == '0);
    end

    // Accept decisions use the pre-edge flags.
    always_comb begin
        wr_accept = WR_ENA && !full;
        rd_accept = RD_ENA && !empty;
    end

    // Next-state for pointers, level, read port and sticky errors.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        end

        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AWIDTH'(1);
            rdata_d  = mem_q[rd_ptr_q];
            rvalid_d = 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + (AWIDTH + 1)'(1);
            2'b01:   level_d = level_q - (AWIDTH + 1)'(1);
            default: level_d = level_q;
        endcase

        // Clearing wins over an error raised in the same cycle.
        if (ERR_CLR) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (WR_ENA && full) ovf_d = 1'b1;
            if (RD_ENA && empty) udf_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset overrides any request.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; not cleared on reset since empty pointers hide stale words.
    always_ff @(posedge PCLK) begin
        if (wr_accept && !PRESET) begin
            mem_q[wr_ptr_q] <= WDATA;
        end
    end

    // Output mapping.
    always_comb begin
        RDATA       = rdata_q;
        RVALID      = rvalid_q;
        FULL        = full;
        EMPTY       = empty;
        ALMOST_FULL = (level_q >= AF_L);
        LEVEL       = level_q;
        OVERFLOW    = ovf_q;
        UNDERFLOW   = udf_q;
        ERROR       = ovf_q | udf_q;
    end

endmodule

// File: tb/tb_i2c_fifo.sv
// tb_i2c_fifo: directed bench for i2c_fifo with an expected-data queue.
module tb_i2c_fifo;

    localparam int W = 32;

    logic          PCLK;
    logic          PRESET;
    logic          WR_ENA;
    logic [W-1:0]  WDATA;
    logic          RD_ENA;
    logic          ERR_CLR;
    logic [W-1:0]  RDATA;
    logic          RVALID;
    logic          FULL;
    logic          EMPTY;
    logic          ALMOST_FULL;
    logic [4:0]    LEVEL;
    logic          OVERFLOW;
    logic          UNDERFLOW;
    logic          ERROR;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_rdata;

    i2c_fifo #(.DWIDTH(32), .AWIDTH(4), .AF_LEVEL(14)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .WR_ENA      (WR_ENA),
        .WDATA       (WDATA),
        .RD_ENA      (RD_ENA),
        .ERR_CLR     (ERR_CLR),
        .RDATA       (RDATA),
        .RVALID      (RVALID),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .ALMOST_FULL (ALMOST_FULL),
        .LEVEL       (LEVEL),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW),
        .ERROR       (ERROR)
    );

    // Clock.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One cycle with the given requests; scoreboard tracks accepted traffic.
    task automatic cycle(input logic wr, input logic [W-1:0] wd, input logic rd);
        logic         was_full;
        logic         was_empty;
        logic         rd_ok;
        logic [W-1:0] exp_rd;
        was_full  = (exp_q.size() == 16);
        was_empty = (exp_q.size() == 0);
        rd_ok     = rd && !was_empty;
        exp_rd    = last_rdata;
        if (rd_ok) exp_rd = exp_q.pop_front();
        if (wr && !was_full) exp_q.push_back(wd);
        WR_ENA = wr;
        WDATA  = wd;
        RD_ENA = rd;
        tick();
        WR_ENA = 1'b0;
        RD_ENA = 1'b0;
        check_eq("rvalid", 32'(RVALID), 32'(rd_ok));
        check_eq("rdata", RDATA, exp_rd);
        check_eq("level", 32'(LEVEL), 32'(exp_q.size()));
        last_rdata = exp_rd;
    endtask

    task automatic clear_errors();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
    endtask

    initial begin
        PRESET  = 1'b1;
        WR_ENA  = 1'b0;
        WDATA   = '0;
        RD_ENA  = 1'b0;
        ERR_CLR = 1'b0;
        last_rdata = '0;

        // Reset state.
        tick();
        tick();
        PRESET = 1'b0;
        check_eq("rst_empty", 32'(EMPTY), 32'd1);
        check_eq("rst_full", 32'(FULL), 32'd0);
        check_eq("rst_af", 32'(ALMOST_FULL), 32'd0);
        check_eq("rst_level", 32'(LEVEL), 32'd0);
        check_eq("rst_rvalid", 32'(RVALID), 32'd0);
        check_eq("rst_rdata", RDATA, 32'd0);
        check_eq("rst_error", 32'(ERROR), 32'd0);

        // Fill with 1..16; almost-full from 14, full at 16.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 32'(i), 1'b0);
            check_eq("fill_af", 32'(ALMOST_FULL), 32'(i >= 14));
            check_eq("fill_full", 32'(FULL), 32'(i == 16));
            check_eq("fill_empty", 32'(EMPTY), 32'd0);
        end

        // Overflow at full; the rejected word must never come out.
        cycle(1'b1, 32'hDEADBEEF, 1'b0);
        check_eq("ovf_flag", 32'(OVERFLOW), 32'd1);
        check_eq("ovf_error", 32'(ERROR), 32'd1);
        check_eq("ovf_level", 32'(LEVEL), 32'd16);
        clear_errors();
        check_eq("ovf_clr", 32'(OVERFLOW), 32'd0);
        check_eq("ovf_clr_err", 32'(ERROR), 32'd0);

        // Drain: 1..16 in order, one-cycle latency.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, '0, 1'b1);
            check_eq("drain_val", RDATA, 32'(i));
        end
        tick();
        check_eq("drain_rvalid_low", 32'(RVALID), 32'd0);
        check_eq("drain_rdata_hold", RDATA, 32'd16);
        check_eq("drain_empty", 32'(EMPTY), 32'd1);

        // Underflow on empty: no data, RDATA held.
        cycle(1'b0, '0, 1'b1);
        check_eq("udf_flag", 32'(UNDERFLOW), 32'd1);
        check_eq("udf_error", 32'(ERROR), 32'd1);
        check_eq("udf_rdata", RDATA, 32'd16);
        // Clear in the same cycle as a fresh underflow: clear wins.
        ERR_CLR = 1'b1;
        cycle(1'b0, '0, 1'b1);
        ERR_CLR = 1'b0;
        check_eq("clr_priority", 32'(UNDERFLOW), 32'd0);

        // Simultaneous read/write at level 5 for 20 cycles, pointers wrap.
        for (int k = 0; k < 5; k++) cycle(1'b1, 32'h100 + 32'(k), 1'b0);
        for (int j = 0; j < 20; j++) cycle(1'b1, 32'h200 + 32'(j), 1'b1);
        check_eq("sim_level", 32'(LEVEL), 32'd5);
        check_eq("sim_last_rd", RDATA, 32'h20E);
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1);
        check_eq("sim_tail", RDATA, 32'h213);
        check_eq("sim_empty", 32'(EMPTY), 32'd1);

        // At full with both requests: only the read is taken.
        for (int k = 0; k < 16; k++) cycle(1'b1, 32'h300 + 32'(k), 1'b0);
        check_eq("both_full_pre", 32'(FULL), 32'd1);
        cycle(1'b1, 32'hBADBAD00, 1'b1);
        check_eq("both_full_rd", RDATA, 32'h300);
        check_eq("both_full_lvl", 32'(LEVEL), 32'd15);
        check_eq("both_full_ovf", 32'(OVERFLOW), 32'd1);
        check_eq("both_full_udf", 32'(UNDERFLOW), 32'd0);
        clear_errors();
        for (int k = 0; k < 15; k++) cycle(1'b0, '0, 1'b1);
        check_eq("both_full_tail", RDATA, 32'h30F);

        // At empty with both requests: only the write is taken.
        cycle(1'b1, 32'hA5A5A5A5, 1'b1);
        check_eq("both_empty_lvl", 32'(LEVEL), 32'd1);
        check_eq("both_empty_udf", 32'(UNDERFLOW), 32'd1);
        check_eq("both_empty_ovf", 32'(OVERFLOW), 32'd0);
        cycle(1'b0, '0, 1'b1);
        check_eq("both_empty_rd", RDATA, 32'hA5A5A5A5);
        clear_errors();

        // Reset mid-stream at level 9 while writing.
        for (int k = 0; k < 9; k++) cycle(1'b1, 32'h400 + 32'(k), 1'b0);
        check_eq("mid_level9", 32'(LEVEL), 32'd9);
        cycle(1'b0, '0, 1'b1);           // leave UNDERFLOW clear, set RDATA
        cycle(1'b1, 32'h401, 1'b0);
        PRESET = 1'b1;
        WR_ENA = 1'b1;
        RD_ENA = 1'b1;
        WDATA  = 32'h77777777;
        tick();
        PRESET = 1'b0;
        WR_ENA = 1'b0;
        RD_ENA = 1'b0;
        exp_q.delete();
        last_rdata = '0;
        check_eq("mrst_level", 32'(LEVEL), 32'd0);
        check_eq("mrst_empty", 32'(EMPTY), 32'd1);
        check_eq("mrst_full", 32'(FULL), 32'd0);
        check_eq("mrst_error", 32'(ERROR), 32'd0);
        check_eq("mrst_rvalid", 32'(RVALID), 32'd0);
        check_eq("mrst_rdata", RDATA, 32'd0);
        cycle(1'b1, 32'hCAFE0001, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check_eq("mrst_new_word", RDATA, 32'hCAFE0001);
        check_eq("mrst_final_empty", 32'(EMPTY), 32'd1);

        // Report.
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_fifo.md
I2C_FIFO -- requirements
Module: i2c_fifo

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 32, data word width.
REQ-002 The module SHALL have parameter AWIDTH, default 4, address width; DEPTH = 2**AWIDTH = 16 entries.
REQ-003 The module SHALL have parameter AF_LEVEL, default 14, almost-full threshold in entries.
REQ-004 The module SHALL have port PCLK, input, 1 bit, single clock; all logic on its rising edge.
REQ-005 The module SHALL have port PRESET, input, 1 bit, synchronous active-high reset.
REQ-006 The module SHALL have port WR_ENA, input, 1 bit, write request.
REQ-007 The module SHALL have port WDATA, input, DWIDTH bits, write data.
REQ-008 The module SHALL have port RD_ENA, input, 1 bit, read request.
REQ-009 The module SHALL have port ERR_CLR, input, 1 bit, clears sticky error flags.
REQ-010 The module SHALL have port RDATA, output, DWIDTH bits, registered read data.
REQ-011 The module SHALL have port RVALID, output, 1 bit, RDATA holds newly read word this cycle.
REQ-012 The module SHALL have port FULL, output, 1 bit, LEVEL == DEPTH.
REQ-013 The module SHALL have port EMPTY, output, 1 bit, LEVEL == 0.
REQ-014 The module SHALL have port ALMOST_FULL, output, 1 bit, LEVEL >= AF_LEVEL.
REQ-015 The module SHALL have port LEVEL, output, AWIDTH+1 bits, current occupancy.
REQ-016 The module SHALL have port OVERFLOW, output, 1 bit, sticky: write attempted while full.
REQ-017 The module SHALL have port UNDERFLOW, output, 1 bit, sticky: read attempted while empty.
REQ-018 The module SHALL have port ERROR, output, 1 bit, OVERFLOW OR UNDERFLOW, combinational.

Function
REQ-019 The module SHALL store words in a DEPTH x DWIDTH array addressed by AWIDTH-bit write and read pointers.
REQ-020 A write SHALL be accepted iff WR_ENA=1 and FULL=0; WDATA goes to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
REQ-021 A read SHALL be accepted iff RD_ENA=1 and EMPTY=0; mem[rd_ptr] is registered into RDATA, rd_ptr increments modulo DEPTH, and RVALID=1 the next cycle.
REQ-022 Read latency SHALL be exactly one cycle, RD_ENA edge to RDATA/RVALID.
REQ-023 RVALID SHALL be 0 in any cycle not following an accepted read, and RDATA SHALL hold its last value.
REQ-024 LEVEL SHALL update as follows: +1 on a write alone, -1 on a read alone, unchanged when both are accepted in the same cycle.
REQ-025 Acceptance SHALL be evaluated on pre-edge flags, which means:
- when full with WR_ENA and RD_ENA both high, only the read is accepted and OVERFLOW sets;
- when empty with both high, only the write is accepted and UNDERFLOW sets.
REQ-026 Simultaneous accepted read and write at LEVEL 1..DEPTH-1 SHALL both complete; the read returns the oldest word.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of ordering; data SHALL exit strictly first-in first-out.
REQ-028 FULL, EMPTY, ALMOST_FULL and LEVEL SHALL be registered or derived from registered state only, reflecting post-edge occupancy.
REQ-029 OVERFLOW/UNDERFLOW SHALL set the cycle after the offending request and hold until ERR_CLR=1 or reset.
REQ-030 ERR_CLR has priority over a simultaneous new error, so the flag SHALL read 0 after that edge.
REQ-031 A rejected request SHALL NOT modify pointers, LEVEL, memory or RDATA.

Reset
REQ-032 When PRESET=1 at a rising PCLK edge, the following SHALL reset:
- wr_ptr=0, rd_ptr=0, LEVEL=0;
- EMPTY=1, FULL=0, ALMOST_FULL=0;
- RVALID=0, RDATA=0;
- OVERFLOW=0, UNDERFLOW=0.
REQ-033 Reset SHALL override any concurrent WR_ENA/RD_ENA, including mid-stream, so the FIFO reads empty the following cycle.
REQ-034 Memory contents SHALL NOT need clearing on reset; stale data SHALL never be visible via RVALID.

Verification
REQ-035 Fill/drain: write 0x00000001..0x00000010 (16 words) -> FULL=1, LEVEL=16, ALMOST_FULL=1 from LEVEL 14; 16 reads return 1..16 in order, each with RVALID one cycle after RD_ENA, then EMPTY=1.
REQ-036 Overflow: at FULL, write 0xDEADBEEF -> OVERFLOW=1, ERROR=1, LEVEL stays 16, and 0xDEADBEEF is never read; ERR_CLR=1 -> OVERFLOW=0.
REQ-037 Underflow: on empty, RD_ENA=1 -> UNDERFLOW=1, RVALID=0, RDATA unchanged.
REQ-038 Simultaneous: at LEVEL=5, WR_ENA+RD_ENA for 20 cycles -> LEVEL holds 5, pointers wrap, order preserved; at FULL both high -> LEVEL 15, OVERFLOW=1.
REQ-039 Empty + both: on empty, write 0xA5A5A5A5 with RD_ENA=1 -> LEVEL=1, UNDERFLOW=1, and the next read returns 0xA5A5A5A5.
REQ-040 Reset mid-stream: at LEVEL=9, PRESET=1 for one cycle while writing -> LEVEL=0, EMPTY=1, flags 0; the next write/read returns the new word.
